// File: rtl/attr_trace_serializer.sv
// Captures per-transaction stage attribution records, queues them, and streams
// each record as three 64-bit trace words (header, ingress/core, risk/egress).
module attr_trace_serializer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  MAGIC      = 8'hA7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               attr_valid,
    input  logic [31:0]                        attr_d_ingress,
    input  logic [31:0]                        attr_d_core,
    input  logic [31:0]                        attr_d_risk,
    input  logic [31:0]                        attr_d_egress,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [63:0]                        out_data,
    output logic                               out_last,
    output logic [31:0]                        drop_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] d_ingress;
        logic [31:0] d_core;
        logic [31:0] d_risk;
        logic [31:0] d_egress;
    } record_t;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_W1, S_W2} state_t;

    record_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [15:0]        seq;
    state_t             state;

    logic               push;
    logic               pop;
    record_t            rec_in;
    record_t            head;
    record_t            next_head;

    function automatic logic [63:0] header_word(input record_t r);
        logic [31:0] total;
        total = r.d_ingress + r.d_core + r.d_risk + r.d_egress;
        return {MAGIC, 8'h00, r.seq, total};
    endfunction

    // NOTE: every signal driven here gets an unconditional value, so no latch can be inferred.
    always_comb begin
        push      = attr_valid && (fifo_level < LVL_W'(FIFO_DEPTH));
        pop       = (state == S_W2) && out_ready;
        rec_in    = '{seq: seq, d_ingress: attr_d_ingress, d_core: attr_d_core,
                      d_risk: attr_d_risk, d_egress: attr_d_egress};
        head      = mem[rd_ptr];
        next_head = mem[rd_ptr + PTR_W'(1)];
    end

    // NOTE: record storage has no reset; occupancy is tracked by the pointers and level, which are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    // Full-check uses the pre-cycle level, so a pop never makes room for a same-cycle push.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            seq        <= '0;
            drop_count <= '0;
        end else begin
            if (attr_valid) begin
                seq <= seq + 16'd1;
                if (!push && drop_count != 32'hFFFF_FFFF) begin
                    drop_count <= drop_count + 32'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Outputs are loaded one state ahead, so out_data/out_last are already stable when out_valid is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_level != '0) begin
                        state     <= S_HDR;
                        out_valid <= 1'b1;
                        out_data  <= header_word(head);
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        state    <= S_W1;
                        out_data <= {head.d_ingress, head.d_core};
                    end
                end
                S_W1: begin
                    if (out_ready) begin
                        state    <= S_W2;
                        out_data <= {head.d_risk, head.d_egress};
                        out_last <= 1'b1;
                    end
                end
                S_W2: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        // Another record is already queued behind the head: chain without a bubble.
                        if (fifo_level > LVL_W'(1)) begin
                            state    <= S_HDR;
                            out_data <= header_word(next_head);
                        end else begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/attr_trace_serializer.md
Name: attr_trace_serializer

Overview:
- Consumer end of the pipeline attribution interface: captures each one-cycle `attr_valid` pulse and its four 32-bit stage deltas (ingress, core, risk, egress).
- Queues records in a small FIFO. The attribution interface has no backpressure, so records that arrive while the FIFO is full are dropped and counted.
- Serializes each record into three 64-bit words on a valid/ready trace stream feeding the host DMA/export path.

Parameters:
- FIFO_DEPTH, 8, record slots; power of two, at least 2.
- MAGIC, 8'hA7, tag byte placed in bits [63:56] of every header word.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- attr_valid  in  1  one-cycle pulse; record present
- attr_d_ingress  in  32  ingress stage cycles
- attr_d_core  in  32  core stage cycles
- attr_d_risk  in  32  risk stage cycles
- attr_d_egress  in  32  egress stage cycles
- out_valid  out  1  trace word valid
- out_ready  in  1  downstream accepts word
- out_data  out  64  trace word
- out_last  out  1  high on the final word of a record
- drop_count  out  32  records discarded because the FIFO was full; saturating
- fifo_level  out  $clog2(FIFO_DEPTH+1)  records currently queued

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - out_valid=0, out_last=0, out_data=0.
  - drop_count=0, fifo_level=0.
  - Sequence counter = 0, FSM = S_IDLE, FIFO emptied.
  - Reset mid-record abandons the partial record; no further words are emitted for it.
- Sequence number:
  - 16-bit counter, incremented on every attr_valid, whether the record is accepted or dropped. Gaps in the sequence therefore expose drops.
  - The record takes the counter value before the increment. First record after reset has seq=0.
  - Wraps 16'hFFFF -> 16'h0000.
- Enqueue:
  - On attr_valid, when the registered fifo_level (pre-cycle value) is below FIFO_DEPTH, push {seq, four deltas}.
  - When fifo_level == FIFO_DEPTH, drop the record and increment drop_count, saturating at 32'hFFFF_FFFF.
  - A pop in the same cycle does NOT free space for a push arriving while full; that push is dropped.
  - Simultaneous push and pop with the FIFO not full leaves fifo_level unchanged.
- Word format, per record, in order:
  - W0 (header) = {MAGIC[7:0], 8'h00, seq[15:0], total[31:0]}, where total = sum of the four deltas modulo 2^32 (carries discarded).
  - W1 = {d_ingress, d_core}.
  - W2 = {d_risk, d_egress}, with out_last=1.
- FSM states: S_IDLE, S_HDR, S_W1, S_W2.
  - S_IDLE: out_valid=0. If fifo_level != 0, go to S_HDR.
  - S_HDR / S_W1: out_valid=1. On out_valid && out_ready, advance to the next state.
  - S_W2: out_valid=1, out_last=1. On handshake, pop the FIFO head:
    - if fifo_level > 1 (another record remains after the pop), go to S_HDR with no bubble;
    - otherwise go to S_IDLE.
- Handshake rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Latency: attr_valid at cycle T with the FIFO empty and the FSM in S_IDLE -> header word valid at T+2. With out_ready held high, W1 appears at T+3 and W2 at T+4.
- Throughput: one word per cycle. A record needs 3 cycles, while the source emits at most one record per ~18 cycles, so the FIFO only fills under sustained backpressure.
- fifo_level is registered and reflects the count after the previous cycle's push/pop.

Test Plan:
- Single record, deltas 1/10/5/2, out_ready=1:
  - out_valid rises 2 cycles after attr_valid.
  - Words are W0=64'hA700_0000_0000_0012, W1=64'h0000_0001_0000_000A, W2=64'h0000_0005_0000_0002.
  - out_last is high on W2 only; fifo_level returns to 0.
- Backpressure: out_ready=0 for 7 cycles in the middle of W1 -> out_data and out_valid stay constant; the stream completes correctly once out_ready=1.
- Overflow: out_ready=0, 10 pulses with FIFO_DEPTH=8 -> fifo_level=8, drop_count=2. Releasing out_ready yields 8 records with seq 0..7 and no record for seq 8 or 9.
- Back-to-back: 3 records queued, out_ready=1 -> 9 consecutive valid words, no idle cycle between W2 and the next W0.
- Wrap and arithmetic:
  - Preload 65536 pulses -> the record after seq 16'hFFFF carries seq 0.
  - Deltas all 32'hFFFF_FFFF -> total field = 32'hFFFF_FFFC.
- Reset mid-record: assert rst_n=0 after W1 is accepted -> out_valid=0 immediately and fifo_level=0. After release, the next pulse emits seq 0 with W0 first.
